sseg_display_ctrl: RTL and testbench



---
 rtl/sseg_pkg.sv | 34 +++
 rtl/sseg_hex_decoder.sv | 18 +
 rtl/sseg_display_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_sseg_display_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment display controller.
//   - register offsets (iAddress[10:0])
//   - CTRL bit positions and writable-bit masks
//   - blank pattern and 16-entry active-low hex glyph table
//   - blink phase enum
package sseg_pkg;

  localparam logic [10:0] SSEG_DATA_OFS  = 11'h020;
  localparam logic [10:0] SSEG_CTRL_OFS  = 11'h024;
  localparam logic [10:0] SSEG_RAWLO_OFS = 11'h028;
  localparam logic [10:0] SSEG_RAWHI_OFS = 11'h02C;

  // CTRL[7:0] blank mask, CTRL[15:8] dp mask
  localparam int SSEG_CTRL_DP    = 8;
  localparam int SSEG_CTRL_EN    = 16;
  localparam int SSEG_CTRL_BLINK = 17;
  localparam int SSEG_CTRL_LZS   = 18;
  localparam int SSEG_CTRL_RAW   = 19;

  // Bits of CTRL that are stored; everything else reads back as 0
  localparam logic [31:0] SSEG_CTRL_MASK     = 32'h0007_FFFF;
  localparam logic [31:0] SSEG_CTRL_MASK_RAW = 32'h000F_FFFF;

  localparam logic [7:0] SSEG_BLANK = 8'hFF;

  // Active-low {dp,g,f,e,d,c,b,a}; dp bit is 1 (off) in every entry
  localparam logic [7:0] SSEG_GLYPH [0:15] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef enum logic {PH_ON = 1'b0, PH_OFF = 1'b1} phase_e;

endpackage

// File: rtl/sseg_hex_decoder.sv
// Combinational nibble -> active-low segment byte for one digit.
//   nib : hex value to show
//   dp  : 1 lights the decimal point
//   seg : {dp,g,f,e,d,c,b,a}, active-low
module sseg_hex_decoder
  import sseg_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       dp,
  output logic [7:0] seg
);

  always_comb begin
    seg    = SSEG_GLYPH[nib];
    seg[7] = ~dp;
  end

endmodule

// File: rtl/sseg_display_ctrl.sv
// Memory-mapped controller for eight seven-segment digits.
//   iClk, iReset_n       : clock, asynchronous active-low reset
//   iAddress, iWriteData : I/O bus address (only [10:0] decoded) and write data
//   iWR, iIOS            : write strobe, I/O space select
//   oReadData            : combinational readback, 0 when not selected
//   oSSLED7..oSSLED0     : active-low digit segments {dp,g,f,e,d,c,b,a}
// Registers: DATA @0x020, CTRL @0x024.
// Optional build macro SSEG_RAW_MODE_EN adds RAW_LO @0x028, RAW_HI @0x02C and
// CTRL[19] RAW (lit digits show the raw byte instead of the hex glyph).
module sseg_display_ctrl
  import sseg_pkg::*;
#(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 32,
  parameter int BLINK_DIV = 25_000_000,
  parameter int CNTWIDTH  = 25
) (
  input  logic                 iClk,
  input  logic                 iReset_n,
  input  logic [ADDRWIDTH-1:0] iAddress,
  input  logic [DATAWIDTH-1:0] iWriteData,
  output logic [DATAWIDTH-1:0] oReadData,
  input  logic                 iWR,
  input  logic                 iIOS,
  output logic [7:0]           oSSLED7,
  output logic [7:0]           oSSLED6,
  output logic [7:0]           oSSLED5,
  output logic [7:0]           oSSLED4,
  output logic [7:0]           oSSLED3,
  output logic [7:0]           oSSLED2,
  output logic [7:0]           oSSLED1,
  output logic [7:0]           oSSLED0
);

  localparam int NUM_DIGITS = 8;

`ifdef SSEG_RAW_MODE_EN
  localparam logic [31:0] CTRL_MASK = SSEG_CTRL_MASK_RAW;
`else
  localparam logic [31:0] CTRL_MASK = SSEG_CTRL_MASK;
`endif

  logic [10:0] ofs;
  logic        sel_data, sel_ctrl;
  logic [31:0] data_q, ctrl_q, ctrl_d;

  assign ofs      = iAddress[10:0];
  assign sel_data = iIOS && (ofs == SSEG_DATA_OFS);
  assign sel_ctrl = iIOS && (ofs == SSEG_CTRL_OFS);

  // CTRL as it will be after this edge; the blink FSM looks ahead at it so
  // that clearing BLINK/EN forces the phase ON on the write edge itself.
  assign ctrl_d = (sel_ctrl && iWR) ? (iWriteData & CTRL_MASK) : ctrl_q;

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      data_q <= '0;
      ctrl_q <= '0;
    end else begin
      if (sel_data && iWR) data_q <= iWriteData;
      ctrl_q <= ctrl_d;
    end
  end

`ifdef SSEG_RAW_MODE_EN
  logic        sel_rawlo, sel_rawhi, raw_mode;
  logic [31:0] rawlo_q, rawhi_q;

  assign sel_rawlo = iIOS && (ofs == SSEG_RAWLO_OFS);
  assign sel_rawhi = iIOS && (ofs == SSEG_RAWHI_OFS);
  assign raw_mode  = ctrl_q[SSEG_CTRL_RAW];

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      rawlo_q <= '1;
      rawhi_q <= '1;
    end else begin
      if (sel_rawlo && iWR) rawlo_q <= iWriteData;
      if (sel_rawhi && iWR) rawhi_q <= iWriteData;
    end
  end
`else
  logic raw_mode;
  assign raw_mode = 1'b0;
`endif

  // Readback
  always_comb begin
    oReadData = '0;
    if (sel_data) oReadData = data_q;
    if (sel_ctrl) oReadData = ctrl_q;
`ifdef SSEG_RAW_MODE_EN
    if (sel_rawlo) oReadData = rawlo_q;
    if (sel_rawhi) oReadData = rawhi_q;
`endif
  end

  // Blink FSM
  phase_e              phase_q, phase_d;
  logic [CNTWIDTH-1:0] cnt_q, cnt_d;
  logic                act_q, act_d;

  assign act_q = ctrl_q[SSEG_CTRL_EN] & ctrl_q[SSEG_CTRL_BLINK];
  assign act_d = ctrl_d[SSEG_CTRL_EN] & ctrl_d[SSEG_CTRL_BLINK];

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      phase_q <= PH_ON;
      cnt_q   <= '0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    if (!act_d) begin
      phase_d = PH_ON;
      cnt_d   = '0;
    end else if (act_q) begin
      // Counting only starts the edge after blinking is switched on, so the
      // first ON phase is a full BLINK_DIV cycles long.
      if (cnt_q == CNTWIDTH'(BLINK_DIV - 1)) begin
        cnt_d   = '0;
        phase_d = (phase_q == PH_ON) ? PH_OFF : PH_ON;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Leading-zero chain: allz[n] = nibbles 7..n all zero
  logic [NUM_DIGITS-1:0]      allz, supp, lit;
  logic [NUM_DIGITS-1:0][7:0] hex_seg, seg;

  assign allz[NUM_DIGITS-1] = (data_q[31:28] == 4'h0);

  for (genvar n = 0; n < NUM_DIGITS; n++) begin : g_digit
    logic [7:0] src;

    if (n < NUM_DIGITS - 1) begin : g_chain
      assign allz[n] = allz[n+1] & (data_q[4*n +: 4] == 4'h0);
    end

    // Digit 0 is never suppressed so a zero value still shows "0"
    if (n == 0) begin : g_nosupp
      assign supp[n] = 1'b0;
    end else begin : g_supp
      assign supp[n] = ctrl_q[SSEG_CTRL_LZS] & ~raw_mode & allz[n];
    end

    sseg_hex_decoder u_dec (
      .nib (data_q[4*n +: 4]),
      .dp  (ctrl_q[SSEG_CTRL_DP + n]),
      .seg (hex_seg[n])
    );

`ifdef SSEG_RAW_MODE_EN
    if (n < 4) begin : g_rlo
      assign src = raw_mode ? rawlo_q[8*n +: 8] : hex_seg[n];
    end else begin : g_rhi
      assign src = raw_mode ? rawhi_q[8*(n-4) +: 8] : hex_seg[n];
    end
`else
    assign src = hex_seg[n];
`endif

    assign lit[n] = ctrl_q[SSEG_CTRL_EN] & ~ctrl_q[n] & ~supp[n] & (phase_q == PH_ON);
    assign seg[n] = lit[n] ? src : SSEG_BLANK;
  end

  assign oSSLED0 = seg[0];
  assign oSSLED1 = seg[1];
  assign oSSLED2 = seg[2];
  assign oSSLED3 = seg[3];
  assign oSSLED4 = seg[4];
  assign oSSLED5 = seg[5];
  assign oSSLED6 = seg[6];
  assign oSSLED7 = seg[7];

  logic unused_addr;
  assign unused_addr = ^iAddress[ADDRWIDTH-1:11];

endmodule

// File: tb/tb_sseg_display_ctrl.sv
// Randomized + directed bench for sseg_display_ctrl against a behavioural
// model: register contents, blink phase from elapsed cycles, LZS from
// arithmetic on the data word.
module tb_sseg_display_ctrl;

  localparam int BDIV = 4;

  logic        iClk = 1'b0;
  logic        iReset_n = 1'b0;
  logic [31:0] iAddress = '0;
  logic [31:0] iWriteData = '0;
  logic [31:0] oReadData;
  logic        iWR = 1'b0;
  logic        iIOS = 1'b0;
  logic [7:0]  oSSLED7, oSSLED6, oSSLED5, oSSLED4;
  logic [7:0]  oSSLED3, oSSLED2, oSSLED1, oSSLED0;

  sseg_display_ctrl #(
    .DATAWIDTH(32), .ADDRWIDTH(32), .BLINK_DIV(BDIV), .CNTWIDTH(3)
  ) dut (
    .iClk(iClk), .iReset_n(iReset_n), .iAddress(iAddress),
    .iWriteData(iWriteData), .oReadData(oReadData), .iWR(iWR), .iIOS(iIOS),
    .oSSLED7(oSSLED7), .oSSLED6(oSSLED6), .oSSLED5(oSSLED5), .oSSLED4(oSSLED4),
    .oSSLED3(oSSLED3), .oSSLED2(oSSLED2), .oSSLED1(oSSLED1), .oSSLED0(oSSLED0)
  );

  always #5 iClk = ~iClk;

  logic [63:0] segs;
  assign segs = {oSSLED7, oSSLED6, oSSLED5, oSSLED4, oSSLED3, oSSLED2, oSSLED1, oSSLED0};

  // Model state
  logic [7:0]  gly [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [31:0] m_data, m_ctrl, m_rlo, m_rhi;
  int          t, t_start;
  int          n_chk = 0, n_err = 0;
  bit          pend = 0;
  logic [31:0] pend_a, pend_d;

`ifdef SSEG_RAW_MODE_EN
  localparam logic [31:0] CMASK = 32'h000F_FFFF;
`else
  localparam logic [31:0] CMASK = 32'h0007_FFFF;
`endif

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit blinking();
    return m_ctrl[16] && m_ctrl[17];
  endfunction

  task automatic m_reset();
    m_data = '0; m_ctrl = '0; m_rlo = '1; m_rhi = '1;
    t = 0; t_start = 0;
  endtask

  task automatic m_write(input logic [31:0] a, input logic [31:0] d);
    bit was;
    was = blinking();
    case (a[10:0])
      11'h020: m_data = d;
      11'h024: begin
        m_ctrl = d & CMASK;
        if (blinking() && !was) t_start = t;
      end
`ifdef SSEG_RAW_MODE_EN
      11'h028: m_rlo = d;
      11'h02C: m_rhi = d;
`endif
      default: ;
    endcase
  endtask

  function automatic logic [31:0] exp_rd(input logic [31:0] a, input bit ios);
    if (!ios) return 32'h0;
    case (a[10:0])
      11'h020: return m_data;
      11'h024: return m_ctrl;
`ifdef SSEG_RAW_MODE_EN
      11'h028: return m_rlo;
      11'h02C: return m_rhi;
`endif
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [63:0] exp_segs();
    logic [63:0] r;
    bit on, raw;
    on  = !blinking() || ((((t - t_start) / BDIV) % 2) == 0);
    raw = m_ctrl[19];
    for (int n = 0; n < 8; n++) begin
      logic [7:0] g;
      bit lit;
      lit = m_ctrl[16] && !m_ctrl[n] && on;
      if (m_ctrl[18] && !raw && n > 0 && (m_data >> (4 * n)) == 0) lit = 0;
      g = gly[m_data[4*n +: 4]];
      if (m_ctrl[8+n]) g[7] = 1'b0;
      if (raw) g = (n < 4) ? m_rlo[8*n +: 8] : m_rhi[8*(n-4) +: 8];
      r[8*n +: 8] = lit ? g : 8'hFF;
    end
    return r;
  endfunction

  // One clock edge; model advances, then the segments are compared.
  task automatic tick();
    @(posedge iClk);
    t++;
    if (pend) begin
      m_write(pend_a, pend_d);
      pend = 0;
    end
    #1;
    iWR = 1'b0; iIOS = 1'b0;
    chk("seg", segs, exp_segs());
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge iClk);
    iAddress = a; iWriteData = d; iWR = 1'b1; iIOS = 1'b1;
    pend = 1; pend_a = a; pend_d = d;
    tick();
  endtask

  task automatic bus_rd(input logic [31:0] a, input bit ios);
    iAddress = a; iIOS = ios; iWR = 1'b0;
    #1;
    chk("rd", {32'h0, oReadData}, {32'h0, exp_rd(a, ios)});
    iIOS = 1'b0;
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  logic [31:0] offs [6] = '{32'h020, 32'h024, 32'h028, 32'h02C, 32'h030, 32'h824};

  initial begin
    m_reset();
    #1;
    chk("rst_seg", segs, {8{8'hFF}});
    bus_rd(32'h020, 1);
    bus_rd(32'h024, 1);
    repeat (2) @(negedge iClk);
    iReset_n = 1'b1;
    m_reset();

    // EN=0: nothing lit, DATA reads back
    bus_wr(32'h020, 32'h1234_5678);
    chk("en0", segs, {8{8'hFF}});
    bus_rd(32'h020, 1);

    // EN only, full hex set; visible right after the write edge
    bus_wr(32'h024, 32'h0001_0000);
    bus_wr(32'h020, 32'h89AB_CDEF);
    chk("hex", segs, 64'h8090_8883_C6A1_868E);

    // LZS + dp1 + blank0
    bus_wr(32'h024, 32'h0005_0201);
    bus_wr(32'h020, 32'h0000_0A05);
    chk("lzs", segs, 64'hFFFF_FFFF_FF88_40FF);
    bus_wr(32'h020, 32'h0000_0000);
    chk("lzs0", segs, {8{8'hFF}});
    bus_rd(32'h024, 1);

    // Blink: 4 on, 4 off, on again
    bus_wr(32'h024, 32'h0003_0000);
    chk("bl_on0", segs, {8{8'hC0}});
    ticks(3);
    chk("bl_on3", segs, {8{8'hC0}});
    tick();
    chk("bl_off0", segs, {8{8'hFF}});
    ticks(3);
    chk("bl_off3", segs, {8{8'hFF}});
    tick();
    chk("bl_on_b", segs, {8{8'hC0}});
    // CTRL rewrite keeping BLINK must not restart the count
    bus_wr(32'h024, 32'h0003_0100);
    ticks(3);
    chk("bl_keep", segs, {8{8'hFF}});
    // Clear BLINK during OFF
    bus_wr(32'h024, 32'h0001_0000);
    chk("bl_clr", segs, {8{8'hC0}});
    // Asynchronous reset mid-phase
    bus_wr(32'h024, 32'h0003_0000);
    tick();
    iReset_n = 1'b0;
    #1;
    m_reset();
    chk("arst", segs, {8{8'hFF}});
    #1;
    iReset_n = 1'b1;
    bus_rd(32'h024, 1);

    // Deselected read, unmapped write
    bus_wr(32'h020, 32'hDEAD_BEEF);
    bus_wr(32'h024, 32'h0001_0000);
    bus_rd(32'h024, 0);
    bus_wr(32'h030, 32'h5555_5555);
    bus_rd(32'h020, 1);
    bus_rd(32'h024, 1);
    bus_rd(32'h030, 1);
    bus_rd(32'h028, 1);
    chk("unmap", segs, 64'hDEAD_BEEF_DEAD_BEEF ^ 64'h0 ? exp_segs() : 64'h0);

`ifdef SSEG_RAW_MODE_EN
    bus_wr(32'h028, 32'h7F7F_7F7F);
    bus_wr(32'h024, 32'h0009_0000);
    chk("raw", segs, 64'hFFFF_FFFF_7F7F_7F7F);
`endif

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      int op;
      logic [31:0] a, d;
      op = $urandom_range(0, 5);
      a  = {$urandom, 11'h0} | offs[$urandom_range(0, 5)];
      d  = $urandom;
      case (op)
        0: bus_wr(32'h020, ($urandom_range(0, 1) == 1) ? d : (d >> (4 * $urandom_range(0, 7))));
        1: bus_wr(32'h024, d & (($urandom_range(0, 2) == 0) ? 32'hFFFF_FF00 : 32'hFFFF_FFFF));
        2: bus_wr(a, d);
        3: bus_rd(a, $urandom_range(0, 3) != 0);
        4: begin
          @(negedge iClk);
          iAddress = a; iWriteData = d; iWR = 1'b1; iIOS = 1'b0;
          tick();
        end
        default: ticks($urandom_range(1, 6));
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
